// File: rtl/ql_video_fetch.sv
// ----------------------------------------------------------------------------
// ql_video_fetch
//   Prefetches QL screen words from SDRAM into a small show-ahead FIFO that
//   feeds the ULA pixel shifter. Each line_start arms WORDS_PER_LINE more
//   words. Requests are issued one at a time over a req/ack handshake, and
//   only while the FIFO plus the outstanding request still has room.
//
// Ports
//   clk_video   : QL pixel clock (10.5 MHz)
//   reset       : synchronous, active-low reset
//   frame_start : one-cycle pulse before visible line 0; flushes and rebases
//   line_start  : one-cycle pulse arming one line's worth of fetches
//   membase     : screen base select (0: 19'h10000, 1: 19'h14000), frame_start only
//   addr        : SDRAM word address of the current/next request
//   req         : read request, held until ack
//   ack         : single-cycle acknowledge, din valid in the same cycle
//   din         : SDRAM read data
//   pop         : consumer takes the head word
//   word        : FIFO head word
//   valid       : FIFO not empty
//   underflow   : sticky, set by pop while empty, cleared by frame_start
//
// ql_video_fetch_chk
//   Simulation checker bound inside the top: the FIFO can never be pushed
//   while full.
// ----------------------------------------------------------------------------
module ql_video_fetch_chk #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input logic             clk,
    input logic             reset,
    input logic [CNT_W-1:0] count,
    input logic             push
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        push |-> (count < CNT_W'(DEPTH)));

    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        count <= CNT_W'(DEPTH));
endmodule

module ql_video_fetch #(
    parameter int DEPTH          = 8,
    parameter int WORDS_PER_LINE = 64,
    parameter int LINES          = 256
) (
    input  logic        clk_video,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        membase,
    output logic [18:0] addr,
    output logic        req,
    input  logic        ack,
    input  logic [15:0] din,
    input  logic        pop,
    output logic [15:0] word,
    output logic        valid,
    output logic        underflow
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [8:0]       WPL_C   = 9'(WORDS_PER_LINE);
    localparam logic [8:0]       LINES_C = 9'(LINES);
    localparam logic [18:0]      BASE0_C = 19'h10000;
    localparam logic [18:0]      BASE1_C = 19'h14000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t           state_r, state_nxt_s;
    logic             req_r;
    logic [18:0]      addr_r, addr_nxt_s;
    logic [7:0]       pending_r, pending_nxt_s, pend_dec_s;
    logic [8:0]       pend_sum_s;
    logic [8:0]       line_cnt_r, line_cnt_nxt_s;
    logic [15:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, wr_ptr_nxt_s, rd_ptr_r, rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_r, count_nxt_s, count_kept_s;
    logic [15:0]      word_r, word_nxt_s;
    logic             valid_r;
    logic             underflow_r, underflow_nxt_s;
    logic             push_s, pop_s;

    // An ack only counts for a live request; frame_start discards it.
    assign push_s = (state_r == ST_REQ) && ack && !frame_start;
    assign pop_s  = pop && valid_r && !frame_start;

    // Request FSM next state: one outstanding request, gated by free space.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if ((pending_r != 8'd0) && (count_r < DEPTH_C)) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        if (frame_start) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Datapath next values: address, pending/line counters, FIFO and head.
    always_comb begin
        pend_dec_s      = pending_r - {7'd0, push_s};
        pend_sum_s      = {1'b0, pend_dec_s} + WPL_C;
        pending_nxt_s   = pend_dec_s;
        line_cnt_nxt_s  = line_cnt_r;
        addr_nxt_s      = addr_r;
        underflow_nxt_s = underflow_r;
        count_kept_s    = count_r - CNT_W'(pop_s);
        count_nxt_s     = count_kept_s + CNT_W'(push_s);
        rd_ptr_nxt_s    = rd_ptr_r + PTR_W'(pop_s);
        wr_ptr_nxt_s    = wr_ptr_r + PTR_W'(push_s);
        word_nxt_s      = word_r;

        if (push_s) begin
            addr_nxt_s = addr_r + 19'd1;
        end else begin
            addr_nxt_s = addr_r;
        end

        if (pop && !valid_r) begin
            underflow_nxt_s = 1'b1;
        end else begin
            underflow_nxt_s = underflow_r;
        end

        // A line that cannot be fetched yet simply accumulates in pending.
        if (line_start && (line_cnt_r < LINES_C)) begin
            pending_nxt_s  = pend_sum_s[8] ? 8'hFF : pend_sum_s[7:0];
            line_cnt_nxt_s = line_cnt_r + 9'd1;
        end else begin
            pending_nxt_s  = pend_dec_s;
            line_cnt_nxt_s = line_cnt_r;
        end

        // Head: hold when empty, take din when it lands in an empty FIFO.
        if (count_nxt_s == {CNT_W{1'b0}}) begin
            word_nxt_s = word_r;
        end else if (count_kept_s == {CNT_W{1'b0}}) begin
            word_nxt_s = din;
        end else begin
            word_nxt_s = mem_r[rd_ptr_nxt_s];
        end

        // frame_start flushes everything, then a coincident line_start arms line 0.
        if (frame_start) begin
            addr_nxt_s      = membase ? BASE1_C : BASE0_C;
            underflow_nxt_s = 1'b0;
            count_nxt_s     = {CNT_W{1'b0}};
            rd_ptr_nxt_s    = {PTR_W{1'b0}};
            wr_ptr_nxt_s    = {PTR_W{1'b0}};
            word_nxt_s      = word_r;
            if (line_start) begin
                pending_nxt_s  = WPL_C[7:0];
                line_cnt_nxt_s = 9'd1;
            end else begin
                pending_nxt_s  = 8'd0;
                line_cnt_nxt_s = 9'd0;
            end
        end else begin
            addr_nxt_s = addr_nxt_s;
        end
    end

    // FIFO storage; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk_video) begin
        if (reset && push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_video) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            req_r       <= 1'b0;
            addr_r      <= BASE0_C;
            pending_r   <= 8'd0;
            line_cnt_r  <= 9'd0;
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            word_r      <= 16'd0;
            valid_r     <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_r       <= (state_nxt_s == ST_REQ);
            addr_r      <= addr_nxt_s;
            pending_r   <= pending_nxt_s;
            line_cnt_r  <= line_cnt_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            word_r      <= word_nxt_s;
            valid_r     <= (count_nxt_s != {CNT_W{1'b0}});
            underflow_r <= underflow_nxt_s;
        end
    end

    assign addr      = addr_r;
    assign req       = req_r;
    assign word      = word_r;
    assign valid     = valid_r;
    assign underflow = underflow_r;

    ql_video_fetch_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk   (clk_video),
        .reset (reset),
        .count (count_r),
        .push  (push_s)
    );
endmodule

// File: tb/tb_ql_video_fetch.sv
// ----------------------------------------------------------------------------
// tb_ql_video_fetch
//   Drives ql_video_fetch with directed scenarios and a randomized phase.
//   A transaction-level model (queue of words, word counters, next address)
//   is updated at every rising edge and compared with the DUT every cycle.
// ----------------------------------------------------------------------------
module tb_ql_video_fetch;
    localparam int DEPTH = 8;
    localparam int WPL   = 64;
    localparam int LINES = 256;

    logic        clk_video = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic        membase = 1'b0;
    logic [18:0] addr;
    logic        req;
    logic        ack = 1'b0;
    logic [15:0] din = 16'd0;
    logic        pop = 1'b0;
    logic [15:0] word;
    logic        valid;
    logic        underflow;

    ql_video_fetch #(
        .DEPTH          (DEPTH),
        .WORDS_PER_LINE (WPL),
        .LINES          (LINES)
    ) dut (
        .clk_video   (clk_video),
        .reset       (reset),
        .frame_start (frame_start),
        .line_start  (line_start),
        .membase     (membase),
        .addr        (addr),
        .req         (req),
        .ack         (ack),
        .din         (din),
        .pop         (pop),
        .word        (word),
        .valid       (valid),
        .underflow   (underflow)
    );

    // Pixel clock.
    always #5 clk_video = ~clk_video;

    int          n_checks = 0;
    int          n_err = 0;
    // Reference model state
    logic [15:0] m_q[$];
    int          m_pend = 0;
    int          m_lines = 0;
    logic [18:0] m_addr = 19'h10000;
    logic        m_uf = 1'b0;
    logic        m_ack_prev = 1'b0;
    // Statistics
    logic [15:0] pushed[$];
    int          n_acks = 0;
    int          n_pops = 0;
    int          n_req_rise = 0;
    logic        req_prev = 1'b0;
    logic [18:0] first_req_addr = 19'd0;
    logic [18:0] last_ack_addr = 19'd0;
    // Responder
    int          req_age = 0;
    int          ack_lat = 0;
    int          stale_mode = 0;
    logic        ack_ok = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit had;
        had = (m_q.size() != 0);
        m_ack_prev = ack_ok;
        if (!reset) begin
            m_q.delete();
            m_pend = 0; m_lines = 0; m_addr = 19'h10000; m_uf = 1'b0;
        end else if (frame_start) begin
            m_q.delete();
            m_addr = membase ? 19'h14000 : 19'h10000;
            m_uf = 1'b0; m_pend = 0; m_lines = 0;
            if (line_start) begin
                m_pend = WPL; m_lines = 1;
            end
        end else begin
            if (pop) begin
                if (had) begin
                    void'(m_q.pop_front());
                    n_pops++;
                end else begin
                    m_uf = 1'b1;
                end
            end
            if (ack_ok) begin
                m_q.push_back(din);
                pushed.push_back(din);
                m_addr = m_addr + 19'd1;
                m_pend--;
                n_acks++;
            end
            if (line_start && m_lines < LINES) begin
                m_pend = (m_pend + WPL > 255) ? 255 : m_pend + WPL;
                m_lines++;
            end
        end
    endtask

    task automatic compare_all();
        check("addr", 32'(addr), 32'(m_addr));
        check("valid", 32'(valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("word", 32'(word), 32'(m_q[0]));
        check("underflow", 32'(underflow), 32'(m_uf));
        if (req) check("req_legal", 32'(m_pend > 0 && m_q.size() < DEPTH), 32'd1);
        if (m_ack_prev) check("req_drop", 32'(req), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk_video);
        model_step();
        @(negedge clk_video);
        compare_all();
        if (req && !req_prev) begin
            if (n_req_rise == 0) first_req_addr = addr;
            n_req_rise++;
        end
        req_prev = req;
    endtask

    task automatic cycle_io(input logic fs, input logic ls, input logic mb, input logic p);
        frame_start = fs; line_start = ls; membase = mb; pop = p;
        if (req) req_age++; else req_age = 0;
        if (req) ack = (req_age > ack_lat);
        else if (stale_mode == 2) ack = 1'b1;
        else if (stale_mode == 1) ack = ($urandom_range(0, 15) == 0);
        else ack = 1'b0;
        ack_ok = ack && req;
        din = 16'($urandom);
        if (ack_ok) last_ack_addr = addr;
        tick();
    endtask

    task automatic clear_stats();
        n_acks = 0; n_pops = 0; n_req_rise = 0; pushed.delete();
    endtask

    initial begin
        bit done;
        int issued;
        int k;

        // ---- Reset state
        reset = 1'b0;
        repeat (3) cycle_io(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_addr", 32'(addr), 32'h10000);
        check("rst_req", 32'(req), 32'd0);
        check("rst_word", 32'(word), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        reset = 1'b1;

        // ---- One line from base 1, consumer keeps up
        ack_lat = 0;
        cycle_io(1'b1, 1'b0, 1'b1, 1'b0);
        clear_stats();
        cycle_io(1'b0, 1'b1, 1'b0, 1'b0);
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            cycle_io(1'b0, 1'b0, 1'b0, valid);
            done = (n_acks == 64) && (m_q.size() == 0) && !req;
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_first_addr", 32'(first_req_addr), 32'h14000);
        check("t1_req_count", 32'(n_req_rise), 32'd64);
        check("t1_ack_count", 32'(n_acks), 32'd64);
        check("t1_final_addr", 32'(addr), 32'h14040);

        // ---- No pops: stops at DEPTH words, one pop buys one more request
        ack_lat = 1;
        cycle_io(1'b1, 1'b1, 1'b0, 1'b0);
        clear_stats();
        repeat (60) cycle_io(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_acks_full", 32'(n_acks), 32'd8);
        check("t2_valid", 32'(valid), 32'd1);
        check("t2_req_idle", 32'(req), 32'd0);
        if (pushed.size() >= 2) check("t2_head", 32'(word), 32'(pushed[0]));
        cycle_io(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) cycle_io(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_acks_more", 32'(n_acks), 32'd9);
        if (pushed.size() >= 2) check("t2_head2", 32'(word), 32'(pushed[1]));

        // ---- Slow consumer (pop every 8), ack latency 3
        ack_lat = 3;
        cycle_io(1'b1, 1'b1, 1'b0, 1'b0);
        clear_stats();
        done = 1'b0;
        k = -1;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (k < 0 && valid) k = 0;
            cycle_io(1'b0, 1'b0, 1'b0, (k >= 0) && (k % 8 == 0) && (n_pops < 64));
            if (k >= 0) k++;
            done = (n_pops == 64);
        end
        check("t3_done", 32'(done), 32'd1);
        check("t3_pops", 32'(n_pops), 32'd64);
        repeat (5) cycle_io(1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_underflow", 32'(underflow), 32'd0);
        check("t3_empty", 32'(valid), 32'd0);

        // ---- Pop while empty is sticky until frame_start
        cycle_io(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) cycle_io(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_uf_set", 32'(underflow), 32'd1);
        cycle_io(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (40) cycle_io(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_filled", 32'(valid), 32'd1);
        check("t4_uf_held", 32'(underflow), 32'd1);
        cycle_io(1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_uf_clr", 32'(underflow), 32'd0);
        check("t4_flushed", 32'(valid), 32'd0);
        check("t4_addr", 32'(addr), 32'h10000);

        // ---- 257 line_starts in one frame
        ack_lat = 0;
        cycle_io(1'b1, 1'b0, 1'b1, 1'b0);
        clear_stats();
        issued = 0;
        done = 1'b0;
        for (int i = 0; i < 60000 && !done; i++) begin
            if (issued < 257 && m_pend < 100) begin
                cycle_io(1'b0, 1'b1, 1'b0, m_q.size() != 0);
                issued++;
            end else begin
                cycle_io(1'b0, 1'b0, 1'b0, m_q.size() != 0);
            end
            done = (issued == 257) && (m_pend == 0) && (m_q.size() == 0) && !req;
        end
        check("t5_done", 32'(done), 32'd1);
        check("t5_acks", 32'(n_acks), 32'd16384);
        check("t5_last_addr", 32'(last_ack_addr), 32'h17FFF);
        check("t5_end_addr", 32'(addr), 32'h18000);

        // ---- frame_start coincident with ack
        ack_lat = 100;
        cycle_io(1'b1, 1'b1, 1'b1, 1'b0);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle_io(1'b0, 1'b0, 1'b0, 1'b0);
            done = req;
        end
        check("t6_req_seen", 32'(done), 32'd1);
        ack_lat = 0;
        cycle_io(1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_valid", 32'(valid), 32'd0);
        check("t6_req", 32'(req), 32'd0);
        check("t6_addr", 32'(addr), 32'h10000);
        repeat (3) cycle_io(1'b0, 1'b0, 1'b0, 1'b0);

        // ---- Reset mid-request, stale acks afterwards
        ack_lat = 100;
        cycle_io(1'b1, 1'b1, 1'b1, 1'b0);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle_io(1'b0, 1'b0, 1'b0, 1'b0);
            done = req;
        end
        check("t7_req_seen", 32'(done), 32'd1);
        reset = 1'b0;
        cycle_io(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        check("t7_req_drop", 32'(req), 32'd0);
        stale_mode = 2;
        repeat (3) cycle_io(1'b0, 1'b0, 1'b0, 1'b0);
        stale_mode = 0;
        check("t7_req_idle", 32'(req), 32'd0);
        check("t7_valid", 32'(valid), 32'd0);
        check("t7_addr", 32'(addr), 32'h10000);

        // ---- Randomized traffic
        stale_mode = 1;
        cycle_io(1'b1, 1'b1, 1'($urandom), 1'b0);
        for (int i = 0; i < 6000; i++) begin
            if (i % 500 == 0) ack_lat = $urandom_range(0, 3);
            reset = ($urandom_range(0, 1999) != 0);
            cycle_io(($urandom_range(0, 599) == 0), ($urandom_range(0, 99) == 0),
                     1'($urandom), 1'($urandom));
        end
        reset = 1'b1;
        stale_mode = 0;
        repeat (5) cycle_io(1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
